// File: rtl/ddr_avalon_arb_pkg.sv
// Shared DDR arbiter definitions: bus widths, FSM encoding, read-tag layout.
package ddr_avalon_arb_pkg;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 3;
    localparam int BE_W    = DATA_W / 8;
    localparam int MID_W   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_t;

    // One outstanding read command: who asked for it and how many beats come back.
    typedef struct packed {
        logic [MID_W-1:0]   mid;
        logic [BURST_W-1:0] beats;
    } rd_tag_t;

    // A burst length of zero still moves one beat.
    function automatic logic [BURST_W-1:0] beat_count(input logic [BURST_W-1:0] burst);
        return (burst == '0) ? BURST_W'(1) : burst;
    endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// Show-ahead FIFO of outstanding read tags; a push into a full FIFO is taken
// only when the head is popped in the same cycle.
module ddr_arb_tag_fifo
    import ddr_avalon_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  rd_tag_t push_tag,
    input  logic    pop,
    output rd_tag_t head_tag,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rd_tag_t          mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_tag = mem[rd_ptr[PTR_W-1:0]];

    // Tag storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_tag;
        end
    end

    // Read/write pointers with one wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_avalon_arb.sv
// Two-master Avalon-MM burst arbiter onto one DDR slave port. Commands are
// granted round-robin; read responses are steered back using an in-order tag FIFO.
module ddr_avalon_arb
    import ddr_avalon_arb_pkg::*;
#(
    parameter int RD_TAGS = 4
) (
    input  logic               clk,
    input  logic               i_nrst,
    input  logic [ADDR_W-1:0]  i_m0_targetAddr,
    input  logic [BURST_W-1:0] i_m0_burstLength,
    input  logic               i_m0_writeEnableMem,
    input  logic               i_m0_readEnableMem,
    input  logic [DATA_W-1:0]  i_m0_dataMem,
    input  logic [BE_W-1:0]    i_m0_byteEnableMem,
    output logic               o_m0_busyMem,
    output logic               o_m0_dataValidMem,
    output logic [DATA_W-1:0]  o_m0_dataMem,
    input  logic [ADDR_W-1:0]  i_m1_targetAddr,
    input  logic [BURST_W-1:0] i_m1_burstLength,
    input  logic               i_m1_writeEnableMem,
    input  logic               i_m1_readEnableMem,
    input  logic [DATA_W-1:0]  i_m1_dataMem,
    input  logic [BE_W-1:0]    i_m1_byteEnableMem,
    output logic               o_m1_busyMem,
    output logic               o_m1_dataValidMem,
    output logic [DATA_W-1:0]  o_m1_dataMem,
    output logic [ADDR_W-1:0]  o_targetAddr,
    output logic [BURST_W-1:0] o_burstLength,
    input  logic               i_busyMem,
    output logic               o_writeEnableMem,
    output logic               o_readEnableMem,
    output logic [DATA_W-1:0]  o_dataMem,
    output logic [BE_W-1:0]    o_byteEnableMem,
    input  logic               i_dataValidMem,
    input  logic [DATA_W-1:0]  i_dataMem
);

    arb_state_t         state_q, state_d;
    logic               gnt_id_q, gnt_id_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] wr_left_q, wr_left_d, wr_next;
    logic [BURST_W-1:0] rd_left_q, rd_left_d, head_left;
    logic               rd_err_sticky;

    logic [ADDR_W-1:0]  sel_addr;
    logic [BURST_W-1:0] sel_burst;
    logic               sel_we;
    logic               sel_re;
    logic [DATA_W-1:0]  sel_data;
    logic [BE_W-1:0]    sel_be;

    logic               granted;
    logic               port_ready;
    logic               wr_accept;
    logic               rd_accept;
    logic               req0, req1;
    logic               win_id, win_we;
    logic               rd_beat;

    logic               tag_push, tag_pop, tag_full, tag_empty;
    rd_tag_t            push_tag, head_tag;

    ddr_arb_tag_fifo #(
        .DEPTH (RD_TAGS)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (i_nrst),
        .push     (tag_push),
        .push_tag (push_tag),
        .pop      (tag_pop),
        .head_tag (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Select the granted master's command fields.
    always_comb begin
        sel_addr  = i_m0_targetAddr;
        sel_burst = i_m0_burstLength;
        sel_we    = i_m0_writeEnableMem;
        sel_re    = i_m0_readEnableMem;
        sel_data  = i_m0_dataMem;
        sel_be    = i_m0_byteEnableMem;
        if (gnt_id_q) begin
            sel_addr  = i_m1_targetAddr;
            sel_burst = i_m1_burstLength;
            sel_we    = i_m1_writeEnableMem;
            sel_re    = i_m1_readEnableMem;
            sel_data  = i_m1_dataMem;
            sel_be    = i_m1_byteEnableMem;
        end
    end

    // Slave port is driven only while a grant is held; otherwise everything is 0.
    assign granted          = (state_q != ST_IDLE);
    assign o_targetAddr     = granted ? sel_addr : '0;
    assign o_burstLength    = granted ? beat_count(sel_burst) : '0;
    assign o_dataMem        = granted ? sel_data : '0;
    assign o_byteEnableMem  = granted ? sel_be : '0;
    assign o_writeEnableMem = (state_q == ST_WR) && sel_we;
    assign o_readEnableMem  = (state_q == ST_RD) && sel_re && !tag_full;

    // A full tag FIFO holds the read master off just like a slave wait request.
    assign port_ready   = granted && !i_busyMem && !((state_q == ST_RD) && tag_full);
    assign o_m0_busyMem = !(port_ready && !gnt_id_q);
    assign o_m1_busyMem = !(port_ready && gnt_id_q);

    assign wr_accept = o_writeEnableMem && !i_busyMem;
    assign rd_accept = o_readEnableMem && !i_busyMem;

    assign req0   = i_m0_readEnableMem || i_m0_writeEnableMem;
    assign req1   = i_m1readEnableMem_or_write();
    assign win_id = (req0 && req1) ? rr_ptr_q : req1;
    assign win_we = win_id ? i_m1_writeEnableMem : i_m0_writeEnableMem;

    function automatic logic i_m1readEnableMem_or_write();
        return i_m1_readEnableMem || i_m1_writeEnableMem;
    endfunction

    // Next-state logic: arbitrate in IDLE, issue one read command or a whole write burst.
    always_comb begin
        state_d        = state_q;
        gnt_id_d       = gnt_id_q;
        rr_ptr_d       = rr_ptr_q;
        wr_left_d      = wr_left_q;
        wr_next        = '0;
        tag_push       = 1'b0;
        push_tag.mid   = gnt_id_q;
        push_tag.beats = beat_count(sel_burst);
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_id_d = win_id;
                    rr_ptr_d = ~win_id;
                    state_d  = win_we ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                if (rd_accept) begin
                    tag_push = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!sel_re) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (wr_accept) begin
                    // wr_left_q == 0 marks the first beat of the burst.
                    if (wr_left_q == '0) begin
                        wr_next = beat_count(sel_burst) - 1'b1;
                    end else begin
                        wr_next = wr_left_q - 1'b1;
                    end
                    wr_left_d = wr_next;
                    if (wr_next == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read return: steer each beat to the head tag's master and count down its beats.
    always_comb begin
        rd_beat   = i_dataValidMem && !tag_empty;
        head_left = (rd_left_q == '0) ? beat_count(head_tag.beats) : rd_left_q;
        tag_pop   = rd_beat && (head_left == BURST_W'(1));
        rd_left_d = rd_left_q;
        if (rd_beat) begin
            rd_left_d = tag_pop ? '0 : head_left - 1'b1;
        end
    end

    assign o_m0_dataValidMem = rd_beat && (head_tag.mid == 1'b0);
    assign o_m1_dataValidMem = rd_beat && (head_tag.mid == 1'b1);
    assign o_m0_dataMem      = i_nrst ? i_dataMem : '0;
    assign o_m1_dataMem      = i_nrst ? i_dataMem : '0;

    // Control state registers.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= ST_IDLE;
            gnt_id_q  <= 1'b0;
            rr_ptr_q  <= 1'b0;
            wr_left_q <= '0;
            rd_left_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_left_q <= wr_left_d;
            rd_left_q <= rd_left_d;
        end
    end

    // Sticky flag for read data that arrived with no outstanding command.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_err_sticky <= 1'b0;
        end else if (i_dataValidMem && tag_empty) begin
            rd_err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_avalon_arb.sv
// Bench for ddr_avalon_arb: directed scenarios plus randomized two-master traffic
// checked against a transaction-level model of the arbiter.
module tb_ddr_avalon_arb;
    import ddr_avalon_arb_pkg::*;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic [16:0] i_m0_targetAddr, i_m1_targetAddr;
    logic [2:0]  i_m0_burstLength, i_m1_burstLength;
    logic        i_m0_writeEnableMem, i_m1_writeEnableMem;
    logic        i_m0_readEnableMem, i_m1_readEnableMem;
    logic [63:0] i_m0_dataMem, i_m1_dataMem;
    logic [7:0]  i_m0_byteEnableMem, i_m1_byteEnableMem;
    logic        o_m0_busyMem, o_m1_busyMem;
    logic        o_m0_dataValidMem, o_m1_dataValidMem;
    logic [63:0] o_m0_dataMem, o_m1_dataMem;
    logic [16:0] o_targetAddr;
    logic [2:0]  o_burstLength;
    logic        i_busyMem;
    logic        o_writeEnableMem, o_readEnableMem;
    logic [63:0] o_dataMem;
    logic [7:0]  o_byteEnableMem;
    logic        i_dataValidMem;
    logic [63:0] i_dataMem;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ddr_avalon_arb #(.RD_TAGS(4)) dut (
        .clk(clk), .i_nrst(i_nrst),
        .i_m0_targetAddr(i_m0_targetAddr), .i_m0_burstLength(i_m0_burstLength),
        .i_m0_writeEnableMem(i_m0_writeEnableMem), .i_m0_readEnableMem(i_m0_readEnableMem),
        .i_m0_dataMem(i_m0_dataMem), .i_m0_byteEnableMem(i_m0_byteEnableMem),
        .o_m0_busyMem(o_m0_busyMem), .o_m0_dataValidMem(o_m0_dataValidMem), .o_m0_dataMem(o_m0_dataMem),
        .i_m1_targetAddr(i_m1_targetAddr), .i_m1_burstLength(i_m1_burstLength),
        .i_m1_writeEnableMem(i_m1_writeEnableMem), .i_m1_readEnableMem(i_m1_readEnableMem),
        .i_m1_dataMem(i_m1_dataMem), .i_m1_byteEnableMem(i_m1_byteEnableMem),
        .o_m1_busyMem(o_m1_busyMem), .o_m1_dataValidMem(o_m1_dataValidMem), .o_m1_dataMem(o_m1_dataMem),
        .o_targetAddr(o_targetAddr), .o_burstLength(o_burstLength), .i_busyMem(i_busyMem),
        .o_writeEnableMem(o_writeEnableMem), .o_readEnableMem(o_readEnableMem),
        .o_dataMem(o_dataMem), .o_byteEnableMem(o_byteEnableMem),
        .i_dataValidMem(i_dataValidMem), .i_dataMem(i_dataMem)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_m0_targetAddr = '0; i_m0_burstLength = '0; i_m0_writeEnableMem = 0; i_m0_readEnableMem = 0;
        i_m0_dataMem = '0; i_m0_byteEnableMem = '0;
        i_m1_targetAddr = '0; i_m1_burstLength = '0; i_m1_writeEnableMem = 0; i_m1_readEnableMem = 0;
        i_m1_dataMem = '0; i_m1_byteEnableMem = '0;
        i_busyMem = 0; i_dataValidMem = 0; i_dataMem = '0;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        clear_inputs();
        step();
        step();
        i_nrst = 1'b1;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        clear_inputs();
        i_m0_readEnableMem = 1; i_m1_writeEnableMem = 1;
        i_m0_targetAddr = 17'h1ABCD; i_m1_targetAddr = 17'h0BEEF;
        i_m1_dataMem = 64'hFFFF_0000_1234_5678; i_m1_byteEnableMem = 8'hFF; i_m1_burstLength = 3'd4;
        i_dataValidMem = 1; i_dataMem = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        step();
        n_checks++; if (o_writeEnableMem !== 1'b0 || o_readEnableMem !== 1'b0)
            $display("FAIL rst_enables: got we=%b re=%b want 0 0", o_writeEnableMem, o_readEnableMem); else n_pass++;
        n_checks++; if (o_m0_busyMem !== 1'b1 || o_m1_busyMem !== 1'b1)
            $display("FAIL rst_busy: got %b %b want 1 1", o_m0_busyMem, o_m1_busyMem); else n_pass++;
        n_checks++; if (o_m0_dataValidMem !== 1'b0 || o_m1_dataValidMem !== 1'b0)
            $display("FAIL rst_dv: got %b %b want 0 0", o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
        n_checks++; if (o_targetAddr !== '0 || o_burstLength !== '0 || o_dataMem !== '0 || o_byteEnableMem !== '0)
            $display("FAIL rst_port: got addr=%h burst=%h data=%h be=%h want 0", o_targetAddr, o_burstLength, o_dataMem, o_byteEnableMem); else n_pass++;
        n_checks++; if (o_m0_dataMem !== '0 || o_m1_dataMem !== '0)
            $display("FAIL rst_rdata: got %h %h want 0", o_m0_dataMem, o_m1_dataMem); else n_pass++;
        clear_inputs();
        i_nrst = 1'b1;
        step();
        n_checks++; if (dut.rd_err_sticky !== 1'b0)
            $display("FAIL rst_err: got %b want 0", dut.rd_err_sticky); else n_pass++;
    endtask

    task automatic test_write_burst();
        logic [63:0] d [4];
        logic [7:0]  be;
        for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
        be = 8'($urandom());
        i_m0_targetAddr = 17'h00100; i_m0_burstLength = 3'd4; i_m0_byteEnableMem = be;
        i_m0_writeEnableMem = 1; i_m0_dataMem = d[0];
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b0 || o_m0_busyMem !== 1'b1)
            $display("FAIL wb_idle: got we=%b busy=%b want 0 1", o_writeEnableMem, o_m0_busyMem); else n_pass++;
        step();
        for (int b = 0; b < 4; b++) begin
            i_m0_dataMem = d[b];
            #1;
            n_checks++; if (o_writeEnableMem !== 1'b1 || o_m0_busyMem !== 1'b0)
                $display("FAIL wb_beat%0d_en: got we=%b busy=%b want 1 0", b, o_writeEnableMem, o_m0_busyMem); else n_pass++;
            n_checks++; if (o_targetAddr !== 17'h00100 || o_burstLength !== 3'd4)
                $display("FAIL wb_beat%0d_addr: got %h/%0d want 00100/4", b, o_targetAddr, o_burstLength); else n_pass++;
            n_checks++; if (o_dataMem !== d[b] || o_byteEnableMem !== be)
                $display("FAIL wb_beat%0d_data: got %h/%h want %h/%h", b, o_dataMem, o_byteEnableMem, d[b], be); else n_pass++;
            step();
        end
        i_m0_writeEnableMem = 0;
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b0 || o_readEnableMem !== 1'b0 || o_m0_busyMem !== 1'b1)
            $display("FAIL wb_end: got we=%b re=%b busy=%b want 0 0 1", o_writeEnableMem, o_readEnableMem, o_m0_busyMem); else n_pass++;
        step();
    endtask

    task automatic test_simultaneous();
        logic [16:0] a0, a1;
        logic [63:0] rd;
        do_reset();
        a0 = 17'($urandom()); a1 = 17'($urandom());
        i_m0_targetAddr = a0; i_m0_burstLength = 3'd4; i_m0_readEnableMem = 1;
        i_m1_targetAddr = a1; i_m1_burstLength = 3'd4; i_m1_readEnableMem = 1;
        #1;
        n_checks++; if (o_readEnableMem !== 1'b0)
            $display("FAIL sim_idle0: got re=%b want 0", o_readEnableMem); else n_pass++;
        step();
        #1;
        n_checks++; if (o_readEnableMem !== 1'b1 || o_targetAddr !== a0 || o_m0_busyMem !== 1'b0 || o_m1_busyMem !== 1'b1)
            $display("FAIL sim_cmd_m0: got re=%b addr=%h b0=%b b1=%b want 1 %h 0 1", o_readEnableMem, o_targetAddr, o_m0_busyMem, o_m1_busyMem, a0); else n_pass++;
        step();
        i_m0_readEnableMem = 0;
        #1;
        n_checks++; if (o_readEnableMem !== 1'b0)
            $display("FAIL sim_idle1: got re=%b want 0", o_readEnableMem); else n_pass++;
        step();
        #1;
        n_checks++; if (o_readEnableMem !== 1'b1 || o_targetAddr !== a1 || o_m1_busyMem !== 1'b0 || o_m0_busyMem !== 1'b1)
            $display("FAIL sim_cmd_m1: got re=%b addr=%h b0=%b b1=%b want 1 %h 1 0", o_readEnableMem, o_targetAddr, o_m0_busyMem, o_m1_busyMem, a1); else n_pass++;
        step();
        i_m1_readEnableMem = 0;
        for (int k = 0; k < 8; k++) begin
            rd = {$urandom(), $urandom()};
            i_dataValidMem = 1; i_dataMem = rd;
            #1;
            n_checks++; if (o_m0_dataValidMem !== (k < 4) || o_m1_dataValidMem !== (k >= 4))
                $display("FAIL sim_ret%0d_dv: got %b %b want %b %b", k, o_m0_dataValidMem, o_m1_dataValidMem, k < 4, k >= 4); else n_pass++;
            n_checks++; if (((k < 4) ? o_m0_dataMem : o_m1_dataMem) !== rd)
                $display("FAIL sim_ret%0d_data: got %h want %h", k, (k < 4) ? o_m0_dataMem : o_m1_dataMem, rd); else n_pass++;
            step();
        end
        i_dataValidMem = 0;
    endtask

    task automatic test_stall();
        logic [63:0] d [4];
        logic [16:0] wa, ra;
        for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
        wa = 17'($urandom()); ra = 17'($urandom());
        i_m1_targetAddr = wa; i_m1_burstLength = 3'd4; i_m1_byteEnableMem = 8'hFF;
        i_m1_writeEnableMem = 1; i_m1_dataMem = d[0];
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b0)
            $display("FAIL st_idle: got we=%b want 0", o_writeEnableMem); else n_pass++;
        step();
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b1 || o_dataMem !== d[0] || o_m1_busyMem !== 1'b0)
            $display("FAIL st_beat1: got we=%b data=%h busy=%b want 1 %h 0", o_writeEnableMem, o_dataMem, o_m1_busyMem, d[0]); else n_pass++;
        step();
        i_m1_dataMem = d[1];
        i_m0_targetAddr = ra; i_m0_burstLength = 3'd2; i_m0_readEnableMem = 1;
        i_busyMem = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (o_writeEnableMem !== 1'b1 || o_targetAddr !== wa || o_dataMem !== d[1] || o_m1_busyMem !== 1'b1 || o_m0_busyMem !== 1'b1 || o_readEnableMem !== 1'b0)
                $display("FAIL st_hold%0d: got we=%b addr=%h data=%h b1=%b b0=%b re=%b", c, o_writeEnableMem, o_targetAddr, o_dataMem, o_m1_busyMem, o_m0_busyMem, o_readEnableMem); else n_pass++;
            step();
        end
        i_busyMem = 0;
        for (int b = 1; b < 4; b++) begin
            i_m1_dataMem = d[b];
            #1;
            n_checks++; if (o_writeEnableMem !== 1'b1 || o_dataMem !== d[b] || o_m1_busyMem !== 1'b0 || o_m0_busyMem !== 1'b1 || o_readEnableMem !== 1'b0)
                $display("FAIL st_beat%0d: got we=%b data=%h b1=%b b0=%b re=%b want data %h", b + 1, o_writeEnableMem, o_dataMem, o_m1_busyMem, o_m0_busyMem, o_readEnableMem, d[b]); else n_pass++;
            step();
        end
        i_m1_writeEnableMem = 0;
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b0 || o_readEnableMem !== 1'b0)
            $display("FAIL st_gap: got we=%b re=%b want 0 0", o_writeEnableMem, o_readEnableMem); else n_pass++;
        step();
        #1;
        n_checks++; if (o_readEnableMem !== 1'b1 || o_targetAddr !== ra || o_m0_busyMem !== 1'b0)
            $display("FAIL st_rd: got re=%b addr=%h busy=%b want 1 %h 0", o_readEnableMem, o_targetAddr, o_m0_busyMem, ra); else n_pass++;
        step();
        i_m0_readEnableMem = 0;
        for (int k = 0; k < 2; k++) begin
            i_dataValidMem = 1; i_dataMem = {$urandom(), $urandom()};
            #1;
            n_checks++; if (o_m0_dataValidMem !== 1'b1 || o_m1_dataValidMem !== 1'b0)
                $display("FAIL st_ret%0d: got %b %b want 1 0", k, o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
            step();
        end
        i_dataValidMem = 0;
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        i_m0_targetAddr = 17'($urandom()); i_m0_burstLength = 3'd1; i_m0_readEnableMem = 1;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            #1;
            if (o_readEnableMem && !o_m0_busyMem) acc++;
            step();
        end
        n_checks++; if (acc != 4)
            $display("FAIL ff_accepts: got %0d want 4", acc); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (o_readEnableMem !== 1'b0 || o_m0_busyMem !== 1'b1)
                $display("FAIL ff_stall%0d: got re=%b busy=%b want 0 1", c, o_readEnableMem, o_m0_busyMem); else n_pass++;
            step();
        end
        i_dataValidMem = 1; i_dataMem = {$urandom(), $urandom()};
        #1;
        n_checks++; if (o_m0_dataValidMem !== 1'b1 || o_readEnableMem !== 1'b0)
            $display("FAIL ff_pop: got dv=%b re=%b want 1 0", o_m0_dataValidMem, o_readEnableMem); else n_pass++;
        step();
        i_dataValidMem = 0;
        #1;
        n_checks++; if (o_readEnableMem !== 1'b1 || o_m0_busyMem !== 1'b0)
            $display("FAIL ff_fifth: got re=%b busy=%b want 1 0", o_readEnableMem, o_m0_busyMem); else n_pass++;
        step();
        i_m0_readEnableMem = 0;
        for (int k = 0; k < 4; k++) begin
            i_dataValidMem = 1; i_dataMem = {$urandom(), $urandom()};
            #1;
            n_checks++; if (o_m0_dataValidMem !== 1'b1 || o_m1_dataValidMem !== 1'b0)
                $display("FAIL ff_drain%0d: got %b %b want 1 0", k, o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
            step();
        end
        i_dataValidMem = 0;
    endtask

    task automatic test_reset_mid();
        int  acc = 0;
        int  nb  = 0;
        bit  at_beat3 = 0;
        i_m0_targetAddr = 17'($urandom()); i_m0_burstLength = 3'd1; i_m0_readEnableMem = 1;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            #1;
            if (o_readEnableMem && !o_m0_busyMem) acc++;
            step();
        end
        i_m0_readEnableMem = 0;
        n_checks++; if (acc != 2)
            $display("FAIL rm_reads: got %0d want 2", acc); else n_pass++;
        i_m0_burstLength = 3'd4; i_m0_writeEnableMem = 1; i_m0_dataMem = {$urandom(), $urandom()};
        i_m0_byteEnableMem = 8'hA5;
        for (int c = 0; c < 20 && !at_beat3; c++) begin
            #1;
            if (o_writeEnableMem && !o_m0_busyMem) begin
                if (nb == 2) at_beat3 = 1;
                else begin nb++; step(); i_m0_dataMem = {$urandom(), $urandom()}; end
            end else step();
        end
        n_checks++; if (!at_beat3)
            $display("FAIL rm_beat3: got beats=%0d want 2 before beat 3", nb); else n_pass++;
        i_dataValidMem = 1; i_dataMem = 64'h0123_4567_89AB_CDEF;
        i_nrst = 1'b0;
        #1;
        n_checks++; if (o_writeEnableMem !== 1'b0 || o_readEnableMem !== 1'b0 || o_m0_busyMem !== 1'b1 || o_m1_busyMem !== 1'b1)
            $display("FAIL rm_ctrl: got we=%b re=%b b0=%b b1=%b want 0 0 1 1", o_writeEnableMem, o_readEnableMem, o_m0_busyMem, o_m1_busyMem); else n_pass++;
        n_checks++; if (o_targetAddr !== '0 || o_burstLength !== '0 || o_dataMem !== '0 || o_byteEnableMem !== '0 || o_m0_dataMem !== '0 || o_m1_dataMem !== '0)
            $display("FAIL rm_data: got addr=%h burst=%h data=%h be=%h rd=%h want 0", o_targetAddr, o_burstLength, o_dataMem, o_byteEnableMem, o_m0_dataMem); else n_pass++;
        n_checks++; if (o_m0_dataValidMem !== 1'b0 || o_m1_dataValidMem !== 1'b0)
            $display("FAIL rm_dv: got %b %b want 0 0", o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
        step();
        step();
        clear_inputs();
        i_nrst = 1'b1;
        #1;
        n_checks++; if (dut.rd_err_sticky !== 1'b0)
            $display("FAIL rm_err_clr: got %b want 0", dut.rd_err_sticky); else n_pass++;
        step();
        i_dataValidMem = 1; i_dataMem = {$urandom(), $urandom()};
        #1;
        n_checks++; if (o_m0_dataValidMem !== 1'b0 || o_m1_dataValidMem !== 1'b0)
            $display("FAIL rm_stale_dv: got %b %b want 0 0", o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
        step();
        i_dataValidMem = 0;
        #1;
        n_checks++; if (dut.rd_err_sticky !== 1'b1)
            $display("FAIL rm_err_set: got %b want 1", dut.rd_err_sticky); else n_pass++;
        step();
    endtask

    // Randomized traffic: each master runs one transaction at a time; the model
    // expects whole write bursts without interleaving and read beats returned in
    // command order to the master that issued the command.
    task automatic test_random();
        int          act  [2];
        int          kind [2];
        int          beats[2];
        int          done [2];
        logic [16:0] addr [2];
        logic [63:0] data [2];
        logic [7:0]  be   [2];
        logic [2:0]  burst[2];
        int          ret_q[$];
        int          owner = -1;
        int          exp_m;
        int          m;
        bit          acc [2];
        bit          finished = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin act[i] = 0; kind[i] = 0; beats[i] = 1; done[i] = 0; end
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] == 0 && cyc < 1500 && $urandom_range(0, 2) == 0) begin
                    kind[i]  = $urandom_range(0, 2);
                    burst[i] = 3'($urandom_range(0, 4));
                    beats[i] = (burst[i] == 0) ? 1 : int'(burst[i]);
                    addr[i]  = {1'(i), 16'($urandom())};
                    data[i]  = {$urandom(), $urandom()};
                    be[i]    = 8'($urandom());
                    done[i]  = 0;
                    act[i]   = 1;
                end
            end
            i_m0_targetAddr = addr[0]; i_m0_burstLength = burst[0]; i_m0_dataMem = data[0]; i_m0_byteEnableMem = be[0];
            i_m0_readEnableMem  = (act[0] != 0) && (kind[0] != 1);
            i_m0_writeEnableMem = (act[0] != 0) && (kind[0] != 0);
            i_m1_targetAddr = addr[1]; i_m1_burstLength = burst[1]; i_m1_dataMem = data[1]; i_m1_byteEnableMem = be[1];
            i_m1_readEnableMem  = (act[1] != 0) && (kind[1] != 1);
            i_m1_writeEnableMem = (act[1] != 0) && (kind[1] != 0);
            i_busyMem = ($urandom_range(0, 3) == 0);
            exp_m = -1;
            if (ret_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                i_dataValidMem = 1; i_dataMem = {$urandom(), $urandom()}; exp_m = ret_q[0];
            end else begin
                i_dataValidMem = 0;
            end
            #1;
            if (exp_m >= 0) begin
                void'(ret_q.pop_front());
                n_checks++; if (o_m0_dataValidMem !== (exp_m == 0) || o_m1_dataValidMem !== (exp_m == 1))
                    $display("FAIL rnd_ret_dv c%0d: got %b %b want master %0d", cyc, o_m0_dataValidMem, o_m1_dataValidMem, exp_m); else n_pass++;
                n_checks++; if (((exp_m == 0) ? o_m0_dataMem : o_m1_dataMem) !== i_dataMem)
                    $display("FAIL rnd_ret_data c%0d: got %h want %h", cyc, (exp_m == 0) ? o_m0_dataMem : o_m1_dataMem, i_dataMem); else n_pass++;
            end else begin
                n_checks++; if (o_m0_dataValidMem !== 1'b0 || o_m1_dataValidMem !== 1'b0)
                    $display("FAIL rnd_no_ret c%0d: got %b %b want 0 0", cyc, o_m0_dataValidMem, o_m1_dataValidMem); else n_pass++;
            end
            acc[0] = 0; acc[1] = 0;
            if ((o_writeEnableMem || o_readEnableMem) && !i_busyMem) begin
                m = int'(o_targetAddr[16]);
                acc[m] = 1;
                n_checks++; if (o_targetAddr !== addr[m] || act[m] == 0)
                    $display("FAIL rnd_cmd_addr c%0d: got %h want %h (active %0d)", cyc, o_targetAddr, addr[m], act[m]); else n_pass++;
                n_checks++; if (owner != -1 && owner != m)
                    $display("FAIL rnd_interleave c%0d: got master %0d want %0d", cyc, m, owner); else n_pass++;
                if (o_writeEnableMem) begin
                    n_checks++; if (kind[m] == 0 || o_readEnableMem !== 1'b0 || o_dataMem !== data[m] || o_byteEnableMem !== be[m])
                        $display("FAIL rnd_wr c%0d: got data=%h be=%h re=%b want %h %h 0 (kind %0d)", cyc, o_dataMem, o_byteEnableMem, o_readEnableMem, data[m], be[m], kind[m]); else n_pass++;
                    done[m]++;
                    data[m] = {$urandom(), $urandom()};
                    if (done[m] == beats[m]) begin act[m] = 0; owner = -1; end
                    else owner = m;
                end else begin
                    n_checks++; if (kind[m] != 0)
                        $display("FAIL rnd_rd_kind c%0d: got read want write (kind %0d)", cyc, kind[m]); else n_pass++;
                    for (int b = 0; b < beats[m]; b++) ret_q.push_back(m);
                    act[m] = 0;
                end
            end
            n_checks++; if (o_m0_busyMem !== !acc[0] || o_m1_busyMem !== !acc[1])
                $display("FAIL rnd_busy c%0d: got %b %b want %b %b", cyc, o_m0_busyMem, o_m1_busyMem, !acc[0], !acc[1]); else n_pass++;
            if (cyc >= 1500 && act[0] == 0 && act[1] == 0 && ret_q.size() == 0) finished = 1;
            step();
        end
        n_checks++; if (!finished)
            $display("FAIL rnd_drain: got act=%0d/%0d pending=%0d want all idle", act[0], act[1], ret_q.size()); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_simultaneous();
        test_stall();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr_avalon_arb.md
DDR_AVALON_ARB -- requirements
Module: ddr_avalon_arb

Interface
REQ-001 Parameter RD_TAGS, default 4, SHALL set the depth of the outstanding-read tag FIFO (power of two, 2..16).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock for the whole block.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_mN_targetAddr  in  17  master N (N=0 GPU, N=1 second client) 64-bit-word address.
- i_mN_burstLength  in  3  beats in the burst.
- i_mN_writeEnableMem  in  1  write request.
- i_mN_readEnableMem  in  1  read request.
- i_mN_dataMem  in  64  write data.
- i_mN_byteEnableMem  in  8  write byte enables.
- o_mN_busyMem  out  1  wait request to master N.
- o_mN_dataValidMem  out  1  read beat valid for master N.
- o_mN_dataMem  out  64  read data to master N.
- o_targetAddr  out  17  Avalon address.
- o_burstLength  out  3  Avalon burst count.
- i_busyMem  in  1  Avalon wait request.
- o_writeEnableMem  out  1  Avalon write.
- o_readEnableMem  out  1  Avalon read.
- o_dataMem  out  64  Avalon write data.
- o_byteEnableMem  out  8  Avalon byte enables.
- i_dataValidMem  in  1  Avalon read data valid.
- i_dataMem  in  64  Avalon read data.

Function
REQ-003 Block SHALL arbitrate two Avalon-MM burst masters onto one Avalon-MM slave port.
REQ-004 Beat count SHALL equal burstLength; value 0 SHALL be treated as 1 beat.
REQ-005 Each master's request SHALL be its read or write enable; both asserted together SHALL be served as a write.
REQ-006 FSM states: IDLE, RD, WR.
- IDLE: pick a requester, round-robin.
- Go to RD or WR next cycle, with the grant held in a register.
- Arbitration SHALL cost exactly one idle cycle.
REQ-007 While granted, the master's address, burst, enables, data and byte enables SHALL be muxed combinationally to the slave port.
- All slave enables SHALL be 0 when no grant is held.
REQ-008 o_mN_busyMem SHALL be 1 unless master N holds the grant and i_busyMem=0; in RD it SHALL also need the tag FIFO not full.
REQ-009 RD:
- Command accepted when o_readEnableMem=1 and i_busyMem=0.
- On acceptance, push {master id, beat count} into the tag FIFO and return to IDLE.
REQ-010 WR:
- A beat is accepted when o_writeEnableMem=1 and i_busyMem=0.
- Beat counter loads burstLength at the first beat.
- Return to IDLE after the last beat; the grant SHALL NOT change mid-burst.
REQ-011 Tag FIFO full SHALL force o_readEnableMem=0 and the master's busy=1 in RD.
- Writes from either master SHALL proceed regardless of FIFO state.
REQ-012 Read return path:
- Each i_dataValidMem beat SHALL be steered to the master at the FIFO head, same cycle (combinational).
- i_dataMem SHALL go to both o_mN_dataMem; only the head master's o_mN_dataValidMem=1.
- Head beat count SHALL decrement per beat; the entry SHALL pop on its last beat.
REQ-013 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-014 i_dataValidMem with the FIFO empty SHALL be dropped and set an internal sticky error flag, visible to simulation only.
REQ-015 Round-robin: after serving master N, master 1-N SHALL have priority at the next IDLE decision; a lone requester SHALL win immediately.
REQ-016 Read data SHALL be returned in command order, relying on Avalon in-order responses.

Reset
REQ-017 While i_nrst=0, and asynchronously on its fall:
- FSM to IDLE, grant cleared, round-robin pointer to master 0.
- Tag FIFO emptied and beat counters zeroed.
REQ-018 Reset output values SHALL be o_writeEnableMem=0, o_readEnableMem=0, o_mN_busyMem=1, o_mN_dataValidMem=0.
- Address, burst, data, byte enables and read data SHALL be 0.
REQ-019 Reset mid-burst or with reads outstanding SHALL abandon them; no beat SHALL be delivered after reset release.

Structure
REQ-020 The shared DDR package SHALL hold:
- address width (17), data width (64), burst width (3), master-id width;
- FSM state encoding.
REQ-021 The tag FIFO SHALL be one sub-module, ddr_arb_tag_fifo: synchronous, show-ahead, with full and empty flags.

Verification
REQ-022 Write burst:
- Stimulus: m0 writes burst 4 at 0x00100, busy never asserted.
- Response: one IDLE cycle, then 4 consecutive slave beats with address 0x00100, then IDLE.
REQ-023 Simultaneous requests:
- Stimulus: m0 and m1 each read burst 4, raised in the same cycle from reset.
- Response: m0's command first, m1's 2 cycles later.
- Response: 8 returned beats; the first 4 valid only on m0, the last 4 only on m1.
REQ-024 Stall mid-write:
- Stimulus: i_busyMem=1 for 3 cycles during beat 2 of an m1 write burst 4.
- Response: beat 2 held stable; m0's pending read not granted until beat 4 is accepted.
REQ-025 Tag FIFO full:
- Stimulus: RD_TAGS=4, 5 back-to-back m0 reads of burst 1, no read data returned.
- Response: the 5th read stalls with o_m0_busyMem=1.
- Response: one returned beat pops the FIFO; the 5th command issues the next cycle.
REQ-026 Reset mid-operation:
- Stimulus: i_nrst pulsed low during an m0 write beat 3 of 4 with 2 reads outstanding.
- Response: all outputs at reset values immediately; FIFO empty; later i_dataValidMem raises the error flag only.
